// File: rtl/packet_source.sv
// Transmit end of a router channel: emits fixed-length test packets flit by flit over a
// 4-phase req/ack handshake and counts packets that have been fully handed over.
module packet_source #(
    parameter int ID        = 0,
    parameter int SIZE      = 8,
    parameter int DEST      = 0,
    parameter int PKT_FLITS = 4,
    parameter int GAP       = 0,
    parameter int CNT_BITS  = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_en,
    output logic                o_chReq,
    output logic [SIZE-1:0]     o_chFlit,
    input  logic                i_chAck,
    output logic                o_busy,
    output logic [CNT_BITS-1:0] o_pktCount
);

    localparam int              SUM_W     = ((SIZE > CNT_BITS) ? SIZE : CNT_BITS) + 9;
    localparam logic [7:0]      LAST_IDX  = 8'(PKT_FLITS - 1);
    localparam logic [15:0]     GAP_LAST  = 16'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [SIZE-1:0] HEAD_FLIT = SIZE'(DEST);

    if (PKT_FLITS < 2 || PKT_FLITS > 256 || ID < 0) begin : g_badParams
        $error("packet_source: PKT_FLITS must be 2..256 and ID non-negative");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_REL,
        ST_GAP
    } state_t;

    state_t           r_state;
    logic [7:0]       r_idx;
    logic [15:0]      r_gapCnt;
    logic [SUM_W-1:0] w_sum;
    logic [SIZE-1:0]  w_nextFlit;

    // Payload of flit idx+1 is (packet number + idx + 1); the packet number is the
    // counter value, which only advances once the packet is complete.
    assign w_sum      = SUM_W'(o_pktCount) + SUM_W'(r_idx) + SUM_W'(1);
    assign w_nextFlit = w_sum[SIZE-1:0];

    // A stray ack outside REQ is simply ignored; REL always waits for ack to drop.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_gapCnt   <= '0;
            o_chReq    <= 1'b0;
            o_chFlit   <= '0;
            o_busy     <= 1'b0;
            o_pktCount <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_en) begin
                        o_chFlit <= HEAD_FLIT;
                        o_chReq  <= 1'b1;
                        r_idx    <= '0;
                        o_busy   <= 1'b1;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_chAck) begin
                        o_chReq <= 1'b0;
                        r_state <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (!i_chAck) begin
                        if (r_idx != LAST_IDX) begin
                            r_idx    <= r_idx + 8'd1;
                            o_chFlit <= w_nextFlit;
                            o_chReq  <= 1'b1;
                            r_state  <= ST_REQ;
                        end else begin
                            o_pktCount <= o_pktCount + CNT_BITS'(1);
                            r_gapCnt   <= '0;
                            if (GAP > 0) begin
                                r_state <= ST_GAP;
                            end else begin
                                o_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gapCnt == GAP_LAST) begin
                        o_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt + 16'd1;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
